// File: rtl/pe_col_drain_if.sv
// Handshake bundle between one PE column drain, the array controller and the result writer.
`timescale 1ns/1ps
interface pe_col_drain_if #(
  parameter int ACC_BW = 32,
  parameter int MUL_BW = 16
);
  logic                     start_i;
  logic signed [ACC_BW-1:0] o_i;
  logic                     o_vld_i;
  logic signed [MUL_BW-1:0] res_o;
  logic                     res_vld_o;
  logic                     res_rdy_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     ovf_o;

  modport slave (
    input  start_i, o_i, o_vld_i, res_rdy_i,
    output res_o, res_vld_o, busy_o, done_o, ovf_o
  );

  modport master (
    output start_i, o_i, o_vld_i, res_rdy_i,
    input  res_o, res_vld_o, busy_o, done_o, ovf_o
  );
endinterface

// File: rtl/pe_col_drain.sv
// Bottom-of-column reader: saturates/truncates ACC_BW partial sums to MUL_BW fixed point,
// buffers one tile of DEPTH results and streams them out over valid/ready.
`timescale 1ns/1ps
module pe_col_drain #(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int DEPTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pe_col_drain_if.slave    bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int MAG_W = INT_BW + 2 * FRA_BW;

  // Largest/smallest accumulator values that still fit the result format after the shift.
  localparam logic signed [ACC_BW-1:0] MAXA = $signed((ACC_BW'(1) << MAG_W) - ACC_BW'(1));
  localparam logic signed [ACC_BW-1:0] MINA = ~MAXA;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

  function automatic logic is_sat(input logic signed [ACC_BW-1:0] a);
    return (a > MAXA) || (a < MINA);
  endfunction

  function automatic logic signed [MUL_BW-1:0] sat_round(input logic signed [ACC_BW-1:0] a);
    if (a > MAXA)      return {1'b0, {(MUL_BW-1){1'b1}}};
    else if (a < MINA) return {1'b1, {(MUL_BW-1){1'b0}}};
    else               return a[FRA_BW+MUL_BW-1:FRA_BW];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_e                   state_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         wr_cnt_q;
  logic                     done_q;
  logic                     ovf_q;
  logic signed [MUL_BW-1:0] mem [DEPTH];

  logic                     wr_en;
  logic                     rd_en;
  logic [CNT_W-1:0]         cnt_d;
  logic [CNT_W-1:0]         wr_cnt_d;
  logic signed [MUL_BW-1:0] conv_res;
  logic                     conv_ovf;

  always_comb begin
    wr_en    = (state_q == CAPTURE) && bus.o_vld_i && (wr_cnt_q != CNT_W'(DEPTH));
    rd_en    = (cnt_q != '0) && bus.res_rdy_i;
    cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    wr_cnt_d = wr_cnt_q + CNT_W'(wr_en);
    conv_res = sat_round(bus.o_i);
    conv_ovf = is_sat(bus.o_i);
  end

  // Control: state, pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wr_cnt_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q  <= CAPTURE;
            ovf_q    <= 1'b0;
            wr_cnt_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
            wr_cnt_q <= wr_cnt_d;
            if (conv_ovf) ovf_q <= 1'b1;
          end
          if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
          cnt_q <= cnt_d;
          // Once the whole tile is written, either finish at once or keep draining.
          if (wr_cnt_d == CNT_W'(DEPTH)) begin
            if (cnt_d == '0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rd_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= conv_res;
  end

  assign bus.res_vld_o = (cnt_q != '0);
  assign bus.res_o     = bus.res_vld_o ? mem[rd_ptr_q] : '0;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = done_q;
  assign bus.ovf_o     = ovf_q;

endmodule
